// File: rtl/tick_timer_sched_pkg.sv
// tick_timer_sched shared definitions.
// State encoding and default sizing for the shared tick timer.
package tick_timer_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DIV   = 5000;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_DUR_W = 16;

endpackage

// File: rtl/tick_timer_sched_tick_gen.sv
// Prescaler for the shared timer.
// Counts 0..DIV while enabled; tick marks the terminal count.
module tick_gen #(
    parameter int DIV   = 5000,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_top;

    assign at_top = (cnt == CNT_W'(DIV));
    assign tick   = en & ~clr & at_top;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_top ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_timer_sched.sv
// Shared one-shot timer: round-robin grant of one prescaler and one
// duration counter to NREQ requesters, with a done pulse per grant.
module tick_timer_sched
    import tick_timer_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DIV   = DEF_DIV,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DUR_W-1:0] dur,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  tick
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       state;
    logic [LW-1:0]    last;
    logic [DUR_W-1:0] remaining;

    logic [NREQ-1:0]  rot;
    int               off;
    logic [LW-1:0]    win;
    logic [NREQ-1:0]  win_oh;
    logic [DUR_W-1:0] win_dur;
    logic             own;
    logic             pre_en;

    // Rotate so the search starts at last+1.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[(int'(last) + 1 + i) % NREQ];
        end
    end

    // Find first one, highest index scanned first so the lowest wins.
    always_comb begin
        off = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
    end

    always_comb begin
        win     = LW'((int'(last) + 1 + off) % NREQ);
        win_oh  = NREQ'(1) << win;
        win_dur = dur[int'(win)*DUR_W +: DUR_W];
    end

    assign own    = |(req & gnt);
    assign busy   = (state != IDLE);
    assign pre_en = (state == RUN);

    tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (~pre_en),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            last      <= LW'(NREQ - 1);
            remaining <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= win_oh;
                        last      <= win;
                        remaining <= win_dur;
                        state     <= (win_dur == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!own) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (tick) begin
                        remaining <= remaining - DUR_W'(1);
                        if (remaining == DUR_W'(1)) begin
                            done  <= gnt;
                            gnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Zero-duration grants arrive here with gnt still set.
                    if (|gnt) begin
                        done <= gnt;
                        gnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with DIV=4, NREQ=4, DUR_W=8.
// Observation vector per cycle is {gnt, done, busy, tick}.
module tb_tick_timer_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] dur;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    int nvec = 0;
    int nerr = 0;

    tick_timer_sched #(
        .NREQ  (4),
        .DIV   (4),
        .CNT_W (3),
        .DUR_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dur   (dur),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic apply_reset;
        reset = 1'b1;
        req   = '0;
        dur   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [9:0] obs;
        reset = 1'b1;
        req   = '0;
        dur   = '0;
        #1;
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL reset_async: got %b want %b", obs, 10'b0);
        end
        repeat (2) @(negedge clk);
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL reset_held: got %b want %b", obs, 10'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL reset_idle: got %b want %b", obs, 10'b0);
        end
    endtask

    task automatic test_single;
        logic [9:0] obs, exp;
        dur = {8'd0, 8'd0, 8'd0, 8'd3};
        req = 4'b0001;
        @(negedge clk);
        for (int k = 0; k <= 16; k++) begin
            if (k < 15)
                exp = {4'b0001, 4'b0000, 1'b1,
                       1'(k == 4 || k == 9 || k == 14)};
            else if (k == 15)
                exp = {4'b0000, 4'b0001, 1'b1, 1'b0};
            else
                exp = 10'b0;
            obs = {gnt, done, busy, tick};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL single cyc%0d: got %b want %b", k, obs, exp);
            end
            if (k == 15) req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_rotation;
        logic [9:0] obs, exp;
        logic [3:0] oh;
        dur = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b0101;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            oh = (g % 2 == 0) ? 4'b0001 : 4'b0100;
            for (int k = 0; k < 7; k++) begin
                if (k < 5)
                    exp = {oh, 4'b0000, 1'b1, 1'(k == 4)};
                else if (k == 5)
                    exp = {4'b0000, oh, 1'b1, 1'b0};
                else
                    exp = 10'b0;
                obs = {gnt, done, busy, tick};
                nvec++;
                if (obs !== exp) begin
                    nerr++;
                    $display("FAIL rotation g%0d cyc%0d: got %b want %b",
                             g, k, obs, exp);
                end
                if (g == 3 && k == 5) req = '0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_zero;
        logic [9:0] obs, exp;
        dur = {8'd0, 8'd7, 8'd7, 8'd7};
        req = 4'b1000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k == 0)
                exp = {4'b1000, 4'b0000, 1'b1, 1'b0};
            else if (k == 1)
                exp = {4'b0000, 4'b1000, 1'b1, 1'b0};
            else
                exp = 10'b0;
            obs = {gnt, done, busy, tick};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL zero_dur cyc%0d: got %b want %b", k, obs, exp);
            end
            if (k == 1) req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_abort;
        logic [9:0] obs, exp;
        dur = {8'd0, 8'd3, 8'd4, 8'd0};
        req = 4'b0110;
        @(negedge clk);
        for (int k = 0; k <= 10; k++) begin
            if (k < 7)
                exp = {4'b0010, 4'b0000, 1'b1, 1'(k == 4)};
            else if (k == 7)
                exp = 10'b0;
            else if (k == 8)
                exp = {4'b0100, 4'b0000, 1'b1, 1'b0};
            else
                exp = 10'b0;
            obs = {gnt, done, busy, tick};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL abort cyc%0d: got %b want %b", k, obs, exp);
            end
            if (k == 6) req = 4'b0100;
            if (k == 8) req = 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] obs, exp;
        dur = {8'd2, 8'd2, 8'd2, 8'd2};
        req = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            exp = {4'b0001, 4'b0000, 1'b1, 1'(k == 4)};
            obs = {gnt, done, busy, tick};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL rst_mid run cyc%0d: got %b want %b",
                         k, obs, exp);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL rst_mid async: got %b want %b", obs, 10'b0);
        end
        req = 4'b0101;
        repeat (2) @(negedge clk);
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL rst_mid held: got %b want %b", obs, 10'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        exp = {4'b0001, 4'b0000, 1'b1, 1'b0};
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL rst_mid first_win: got %b want %b", obs, exp);
        end
        req = '0;
        @(negedge clk);
        obs = {gnt, done, busy, tick};
        nvec++;
        if (obs !== 10'b0) begin
            nerr++;
            $display("FAIL rst_mid drop: got %b want %b", obs, 10'b0);
        end
        @(negedge clk);
    endtask

    task automatic test_dur_change;
        logic [9:0] obs, exp;
        dur = {8'd0, 8'd0, 8'd0, 8'd2};
        req = 4'b0001;
        @(negedge clk);
        for (int k = 0; k <= 11; k++) begin
            if (k < 10)
                exp = {4'b0001, 4'b0000, 1'b1, 1'(k == 4 || k == 9)};
            else if (k == 10)
                exp = {4'b0000, 4'b0001, 1'b1, 1'b0};
            else
                exp = 10'b0;
            obs = {gnt, done, busy, tick};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL dur_change cyc%0d: got %b want %b",
                         k, obs, exp);
            end
            if (k == 1) dur = {8'd0, 8'd0, 8'd0, 8'd5};
            if (k == 10) req = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        dur   = '0;
        @(negedge clk);
        test_reset;
        test_single;
        apply_reset;
        test_rotation;
        test_zero;
        test_abort;
        test_reset_mid;
        test_dur_change;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tick_timer_sched.md
# tick_timer_sched

Shared one-shot timer scheduler for the prescaled-tick datapath. It owns a single programmable tick prescaler and one duration down-counter, and shares them among `NREQ` requesters using round-robin arbitration. A granted requester receives a one-cycle `done` pulse after exactly `dur × (DIV+1)` clock cycles. Typical users are debounce, LED-blink and polling-interval logic, which get slow timing without each instancing its own divider.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DIV`, 5000: prescaler terminal count; one tick every `DIV+1` clocks.
- `CNT_W`, 16: prescaler counter width; must satisfy `DIV < 2^CNT_W`.
- `DUR_W`, 16: per-request duration width, in ticks.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `req`, in, `NREQ`: request per channel; held high until `done`.
- `dur`, in, `NREQ*DUR_W`: duration for channel i in `dur[i*DUR_W +: DUR_W]`.
- `gnt`, out, `NREQ`: registered one-hot grant; high while that channel owns the timer.
- `done`, out, `NREQ`: registered one-cycle completion pulse for the owning channel.
- `busy`, out, 1: high in states `RUN` and `DONE`.
- `tick`, out, 1: prescaler tick, exported for observation.

## Operation
- **FSM states:** `IDLE`, `RUN`, `DONE`.
- **`IDLE`:**
  - If `req != 0`, select a winner by round-robin, searching from `last+1` modulo `NREQ`.
  - On the next edge: set `gnt` one-hot, set `last` to the winner, load `remaining` with the winner's `dur`, and clear the prescaler.
  - If the loaded `dur == 0`, go to `DONE`; otherwise go to `RUN`.
- **`RUN`:**
  - The prescaler counts from 0 to `DIV` and wraps to 0. `tick` is high while count equals `DIV`.
  - Each tick decrements `remaining`.
  - When a tick occurs with `remaining == 1`, go to `DONE`.
  - If the owner's `req` is low at an edge, abort to `IDLE`: `gnt` clears and no `done` pulse is issued.
- **`DONE`:**
  - For exactly one cycle, the owner's `done` bit is high and `gnt` is 0.
  - Then go to `IDLE`.
- **Prescaler hold:** while in `IDLE` or `DONE`, the prescaler is held at 0 and `tick` is 0.
- **`dur` sampling:** `dur` is sampled only at the grant edge. Later changes are ignored.
- **Back-to-back requests:** a requester that keeps `req` high through `done` is re-arbitrated. With a single requester this gives a periodic timer.
- **Reset values:**
  - state = `IDLE`; `gnt`, `done`, `busy`, `tick` = 0.
  - prescaler = 0, `remaining` = 0.
  - `last = NREQ-1`, so channel 0 wins first.
- **Reset mid-operation:** asserting `reset` in any state immediately clears all outputs. There is no pending `done` after reset.
- **Arithmetic:** `remaining` is `DUR_W` bits and never underflows, because it is only decremented while ≥1. The prescaler compares only against `DIV`; there is no overflow path.

## Timing
- Let G be the first cycle `gnt[i]` is high. A request seen in `IDLE` in cycle G-1 produces the grant in cycle G.
- **Ticks:** occur in cycles `G + k(DIV+1) - 1`, for k ≥ 1.
- **Normal completion:**
  - `gnt[i]` is high in cycles G through `G + dur(DIV+1) - 1`.
  - `done[i]` is high in cycle `D = G + dur(DIV+1)`.
- **`dur = 0`:** `gnt` is high in cycle G only; `done` is high in G+1.
- **Next grant:** the earliest next grant is cycle D+2, since cycle D+1 is `IDLE`.
- **Abort:** if `req[i]` is low in cycle A while granted, `gnt` is 0 from A+1. The next grant is possible at A+2.
- **`busy`:** high from G through D inclusive.

## Structure
- **Shared package:** the state encoding localparams (`IDLE`/`RUN`/`DONE`), and the default `DIV` and width constants.
- **Sub-module `tick_gen`:**
  - Parameters: `DIV`, `CNT_W`.
  - Ports: `clk`, `reset`, `clr`, `en`, `tick`.
  - Counts while `en`; `clr` has priority.
- **Top level:** the FSM, the round-robin arbiter (rotate, find-first-one, rotate back), and `remaining`.

## Test plan
All scenarios use `DIV=4`, `NREQ=4`, `DUR_W=8`.
- **Single request:** after reset, `req=0001`, `dur0=3`.
  - Expect `gnt[0]` high for 15 cycles, then `done[0]` for 1 cycle.
  - Expect ticks at G+4, G+9, G+14.
- **Contention and rotation:** `req=0101` held, all `dur=1`.
  - Expect grant order 0, 2, 0, 2.
  - Expect each `gnt` high for 5 cycles, `done` at G+5, and the next grant at G+7.
- **Zero duration:** `req=1000`, `dur3=0`. Expect `gnt[3]` for 1 cycle, `done[3]` on the next cycle, and no tick.
- **Abort:** `dur1=4`, drop `req[1]` at G+6.
  - Expect `gnt` = 0 at G+7, no `done`.
  - A pending `req[2]` is granted at G+8.
- **Reset mid-run:** assert `reset` at G+7 of a `dur=2` run.
  - Expect all outputs 0 immediately and no `done`.
  - After release, channel 0 wins first.
- **`dur` change after grant:** change `dur0` from 2 to 5 at G+1. Expect `done` still at G+10.
